// File: rtl/imem_pkg.sv
// Shared definitions for the IMEM port arbiter: reset/idle instruction word,
// arbitration state encoding and IMEM geometry.
package imem_pkg;

    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
    localparam int          IMEM_WORDS = 100;

    typedef enum logic [0:0] {
        PRIO_F = 1'b0,
        PRIO_L = 1'b1
    } arb_state_t;

    // A fetch address is misaligned when it does not sit on a word boundary.
    function automatic logic is_misaligned(input logic [31:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/imem_port_arbiter.sv
// Arbitrates the single IMEM port between core fetch (F) and loader/debug (L),
// registering one-cycle responses. Optional loader writes: IMEM_LOADER_WR_EN.
module imem_port_arbiter
    import imem_pkg::*;
#(
    parameter int unsigned MAX_WAIT  = 8,
    parameter logic [31:0] NOP_INSTR = imem_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        f_req,
    input  logic [31:0] f_addr,
    output logic        f_gnt,
    output logic        f_rsp_valid,
    output logic [31:0] f_rsp_data,
    output logic        f_rsp_err,
    input  logic        l_req,
    input  logic        l_we,
    input  logic [31:0] l_addr,
    input  logic [31:0] l_wdata,
    output logic        l_gnt,
    output logic        l_rsp_valid,
    output logic [31:0] l_rsp_data,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    output logic        mem_we,
    output logic [31:0] mem_wdata
);

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    arb_state_t  state_r;
    arb_state_t  state_nxt_s;
    logic [7:0]  wait_cnt_r;
    logic [7:0]  wait_nxt_s;
    logic        f_gnt_s;
    logic        l_gnt_s;
    logic        wr_s;
    logic        f_rsp_valid_r;
    logic        f_rsp_err_r;
    logic [31:0] f_rsp_data_r;
    logic        l_rsp_valid_r;
    logic [31:0] l_rsp_data_r;

    // Grant selection, starvation counter and next-state logic.
    always_comb begin
        f_gnt_s     = 1'b0;
        l_gnt_s     = 1'b0;
        state_nxt_s = state_r;
        wait_nxt_s  = wait_cnt_r;
        if (rst) begin
            // Grants are combinational from the requests, so they are masked while reset is held.
            state_nxt_s = PRIO_F;
            wait_nxt_s  = 8'd0;
        end else begin
            case (state_r)
                PRIO_F: begin
                    if (f_req) begin
                        f_gnt_s = 1'b1;
                        if (l_req) begin
                            if (wait_cnt_r < MAX_WAIT_C) begin
                                wait_nxt_s = wait_cnt_r + 8'd1;
                            end else begin
                                wait_nxt_s = wait_cnt_r;
                            end
                            if (wait_nxt_s == MAX_WAIT_C) begin
                                state_nxt_s = PRIO_L;
                            end else begin
                                state_nxt_s = PRIO_F;
                            end
                        end else begin
                            state_nxt_s = PRIO_F;
                        end
                    end else if (l_req) begin
                        l_gnt_s    = 1'b1;
                        wait_nxt_s = 8'd0;
                    end else begin
                        state_nxt_s = PRIO_F;
                    end
                end
                PRIO_L: begin
                    // One turn of loader priority; if the loader left, fetch keeps the slot.
                    state_nxt_s = PRIO_F;
                    wait_nxt_s  = 8'd0;
                    if (l_req) begin
                        l_gnt_s = 1'b1;
                    end else if (f_req) begin
                        f_gnt_s = 1'b1;
                    end else begin
                        l_gnt_s = 1'b0;
                    end
                end
                default: begin
                    state_nxt_s = PRIO_F;
                    wait_nxt_s  = 8'd0;
                end
            endcase
        end
    end

`ifdef IMEM_LOADER_WR_EN
    assign wr_s      = l_gnt_s & l_we;
    assign mem_wdata = wr_s ? l_wdata : 32'h0000_0000;
`else
    logic unused_wr_s;
    assign unused_wr_s = l_we ^ (^l_wdata);
    assign wr_s        = 1'b0;
    assign mem_wdata   = 32'h0000_0000;
`endif

    assign mem_we   = wr_s;
    assign mem_addr = f_gnt_s ? f_addr : (l_gnt_s ? l_addr : 32'h0000_0000);

    // Arbiter state and the two one-cycle response registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= PRIO_F;
            wait_cnt_r    <= 8'd0;
            f_rsp_valid_r <= 1'b0;
            f_rsp_err_r   <= 1'b0;
            f_rsp_data_r  <= NOP_INSTR;
            l_rsp_valid_r <= 1'b0;
            l_rsp_data_r  <= NOP_INSTR;
        end else begin
            state_r       <= state_nxt_s;
            wait_cnt_r    <= wait_nxt_s;
            f_rsp_valid_r <= f_gnt_s;
            f_rsp_err_r   <= f_gnt_s & is_misaligned(f_addr);
            if (f_gnt_s) begin
                f_rsp_data_r <= mem_rdata;
            end
            l_rsp_valid_r <= l_gnt_s & ~wr_s;
            if (l_gnt_s && !wr_s) begin
                l_rsp_data_r <= mem_rdata;
            end
        end
    end

    assign f_gnt       = f_gnt_s;
    assign l_gnt       = l_gnt_s;
    assign f_rsp_valid = f_rsp_valid_r;
    assign f_rsp_err   = f_rsp_err_r;
    assign f_rsp_data  = f_rsp_data_r;
    assign l_rsp_valid = l_rsp_valid_r;
    assign l_rsp_data  = l_rsp_data_r;

endmodule
